// File: rtl/phase_ctrl_pkg.sv
// Shared definitions for the phase controller and the phase generator:
// phase bit indices, controller state encoding and error classes.
package phase_ctrl_pkg;

  localparam int PH_F = 4;
  localparam int PH_R = 3;
  localparam int PH_X = 2;
  localparam int PH_M = 1;
  localparam int PH_W = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10,
    ST_ERROR  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_ONEHOT = 2'b01,
    ERR_ORDER  = 2'b10,
    ERR_MEMACK = 2'b11
  } err_t;

  // The phase ring advances w -> m -> x -> r -> f -> w, i.e. a left rotate.
  function automatic logic [4:0] phase_succ(input logic [4:0] p);
    return {p[3:0], p[4]};
  endfunction

endpackage

// File: rtl/phase_ctrl_chk.sv
// Phase sanity checker: classifies the current phase as non-one-hot,
// out-of-order (relative to the previous cycle's phase) or fine.
module phase_chk
  import phase_ctrl_pkg::*;
(
  input  logic [4:0] phase,
  input  logic [4:0] prev_phase,
  output err_t       err_class
);

  // One-hot violations outrank ordering violations.
  always_comb begin
    err_class = ERR_NONE;
    if ($countones(phase) > 1)
      err_class = ERR_ONEHOT;
    else if ((phase == 5'b00000) || (phase != phase_succ(prev_phase)))
      err_class = ERR_ORDER;
  end

endmodule

// File: rtl/phase_ctrl.sv
// Phase controller: tracks the five-phase instruction cycle, issues the
// per-phase datapath strobes, counts fetches and latches halt/error status.
module phase_ctrl
  import phase_ctrl_pkg::*;
#(
  parameter logic [3:0] HLT_OP = 4'hF,
  parameter int         CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       phase,
  input  logic [3:0]       opcode,
  input  logic             mem_ack,
  output logic             ir_we,
  output logic             rf_re,
  output logic             alu_en,
  output logic             mem_req,
  output logic             rf_we,
  output logic             pc_we,
  output logic             hlt,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t     state, next_state;
  err_t       chk_err, det_err, err_q;
  logic [4:0] prev_phase;
  logic       is_mem;
  logic       strobe_en;

  phase_chk u_chk (
    .phase      (phase),
    .prev_phase (prev_phase),
    .err_class  (chk_err)
  );

  assign is_mem   = (opcode[3:2] == 2'b10);
  assign err_code = err_q;

  always_comb begin
    det_err    = ERR_NONE;
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (phase == 5'b00001)
          next_state = ST_RUN;
      end
      ST_RUN: begin
        if (chk_err != ERR_NONE)
          det_err = chk_err;
        else if (phase[PH_M] && is_mem && !mem_ack)
          det_err = ERR_MEMACK;

        if (det_err != ERR_NONE)
          next_state = ST_ERROR;
        else if (phase[PH_X] && (opcode == HLT_OP))
          next_state = ST_HALTED;
      end
      default: next_state = state;
    endcase
  end

  // Strobes are suppressed in the very cycle a fault is seen and during reset.
  assign strobe_en = (state == ST_RUN) && (det_err == ERR_NONE) && !rst;

  assign ir_we   = strobe_en & phase[PH_F];
  assign rf_re   = strobe_en & phase[PH_R];
  assign alu_en  = strobe_en & phase[PH_X];
  assign mem_req = strobe_en & phase[PH_M] & is_mem;
  assign rf_we   = strobe_en & phase[PH_W] & ~is_mem & (opcode != HLT_OP);
  assign pc_we   = strobe_en & phase[PH_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      prev_phase <= 5'b00000;
      hlt        <= 1'b0;
      err_q      <= ERR_NONE;
      instr_cnt  <= '0;
    end else begin
      state      <= next_state;
      prev_phase <= phase;
      hlt        <= (next_state == ST_HALTED) || (next_state == ST_ERROR);
      if ((state == ST_RUN) && (det_err != ERR_NONE))
        err_q <= det_err;
      if ((state == ST_RUN) && phase[PH_F])
        instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_phase_ctrl.sv
// Directed bench for phase_ctrl (CNT_W=4 so the fetch counter wrap is reachable).
module tb_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] phase;
  logic [3:0] opcode;
  logic       mem_ack;
  logic       ir_we, rf_re, alu_en, mem_req, rf_we, pc_we;
  logic       hlt;
  logic [1:0] err_code;
  logic [3:0] instr_cnt;
  logic [5:0] strobes;

  int total = 0;
  int bad   = 0;

  phase_ctrl #(.HLT_OP(4'hF), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .phase     (phase),
    .opcode    (opcode),
    .mem_ack   (mem_ack),
    .ir_we     (ir_we),
    .rf_re     (rf_re),
    .alu_en    (alu_en),
    .mem_req   (mem_req),
    .rf_we     (rf_we),
    .pc_we     (pc_we),
    .hlt       (hlt),
    .err_code  (err_code),
    .instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  assign strobes = {ir_we, rf_re, alu_en, mem_req, rf_we, pc_we};

  task automatic applyStimulus(input logic [4:0] ph, input logic [3:0] op, input logic ack);
    phase   = ph;
    opcode  = op;
    mem_ack = ack;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(5'b00000, 4'h0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  task automatic checkStatus(input string tag, input logic h, input logic [1:0] e);
    checkOutput({tag, "_hlt"}, 8'(hlt), 8'(h));
    checkOutput({tag, "_err"}, 8'(err_code), 8'(e));
  endtask

  initial begin
    rst = 1'b1;
    phase = 5'b0; opcode = 4'h0; mem_ack = 1'b0;
    tick();

    // reset state, strobes forced low while rst is held
    checkStatus("reset", 1'b0, 2'b00);
    checkOutput("reset_cnt", 8'(instr_cnt), 8'd0);
    applyStimulus(5'b00001, 4'h0, 1'b0);
    checkOutput("rst_strobes", 8'(strobes), 8'h00);
    tick();
    rst = 1'b0;

    // startup and one full instruction
    applyStimulus(5'b00001, 4'h0, 1'b0);
    checkOutput("idle_w", 8'(strobes), 8'h00);
    tick();
    applyStimulus(5'b00010, 4'h0, 1'b1);
    checkOutput("run_m", 8'(strobes), 8'h00);
    tick();
    applyStimulus(5'b00100, 4'h0, 1'b0);
    checkOutput("run_x", 8'(strobes), 8'b001000);
    tick();
    applyStimulus(5'b01000, 4'h0, 1'b0);
    checkOutput("run_r", 8'(strobes), 8'b010000);
    tick();
    applyStimulus(5'b10000, 4'h0, 1'b0);
    checkOutput("run_f", 8'(strobes), 8'b100000);
    tick();
    checkOutput("cnt_one", 8'(instr_cnt), 8'd1);
    applyStimulus(5'b00001, 4'h0, 1'b0);
    checkOutput("run_w", 8'(strobes), 8'b000011);
    tick();
    checkStatus("run_ok", 1'b0, 2'b00);

    // halt on x phase with HLT_OP
    applyStimulus(5'b00010, 4'h0, 1'b0);
    tick();
    applyStimulus(5'b00100, 4'hF, 1'b0);
    checkOutput("halt_x", 8'(strobes), 8'b001000);
    tick();
    checkStatus("halted", 1'b1, 2'b00);
    applyStimulus(5'b00000, 4'h0, 1'b0);
    checkOutput("halt_strobes", 8'(strobes), 8'h00);
    tick();
    tick();
    checkStatus("halt_hold", 1'b1, 2'b00);

    // order violation
    doReset();
    checkStatus("rst2", 1'b0, 2'b00);
    applyStimulus(5'b00001, 4'h0, 1'b0); tick();
    applyStimulus(5'b00010, 4'h0, 1'b0); tick();
    applyStimulus(5'b01000, 4'h0, 1'b0);
    checkOutput("order_strobes", 8'(strobes), 8'h00);
    tick();
    checkStatus("order", 1'b1, 2'b10);
    applyStimulus(5'b00011, 4'h0, 1'b0); tick();
    checkStatus("order_sticky", 1'b1, 2'b10);

    // memory handshake
    doReset();
    applyStimulus(5'b00001, 4'h8, 1'b1); tick();
    applyStimulus(5'b00010, 4'h8, 1'b1);
    checkOutput("mem_req", 8'(strobes), 8'b000100);
    tick();
    checkStatus("mem_ok", 1'b0, 2'b00);
    applyStimulus(5'b00100, 4'h8, 1'b0); tick();
    applyStimulus(5'b01000, 4'h8, 1'b0); tick();
    applyStimulus(5'b10000, 4'h8, 1'b0); tick();
    applyStimulus(5'b00001, 4'h8, 1'b0);
    checkOutput("mem_w_no_rfwe", 8'(strobes), 8'b000001);
    tick();
    applyStimulus(5'b00010, 4'h8, 1'b0);
    checkOutput("memack_strobes", 8'(strobes), 8'h00);
    tick();
    checkStatus("memack", 1'b1, 2'b11);

    // non-one-hot, then mid-run reset
    doReset();
    applyStimulus(5'b00001, 4'h0, 1'b0); tick();
    applyStimulus(5'b10000, 4'h0, 1'b0);
    checkOutput("pre_onehot_f", 8'(strobes), 8'h00);
    tick();
    doReset();
    applyStimulus(5'b00001, 4'h0, 1'b0); tick();
    applyStimulus(5'b00110, 4'h0, 1'b0); tick();
    checkStatus("onehot", 1'b1, 2'b01);
    doReset();
    checkStatus("rst_mid", 1'b0, 2'b00);
    checkOutput("rst_mid_cnt", 8'(instr_cnt), 8'd0);

    // nonzero phases other than w are ignored in IDLE
    applyStimulus(5'b00010, 4'h0, 1'b0); tick();
    applyStimulus(5'b00100, 4'h0, 1'b0);
    checkOutput("idle_ignore", 8'(strobes), 8'h00);
    tick();
    checkStatus("idle_ignore", 1'b0, 2'b00);

    // several faults at once: one-hot outranks missing mem_ack
    doReset();
    applyStimulus(5'b00001, 4'h8, 1'b0); tick();
    applyStimulus(5'b00011, 4'h8, 1'b0); tick();
    checkStatus("prio", 1'b1, 2'b01);

    // fetch counter wrap at 4 bits
    doReset();
    applyStimulus(5'b00001, 4'h0, 1'b0); tick();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(5'b00010, 4'h0, 1'b0); tick();
      applyStimulus(5'b00100, 4'h0, 1'b0); tick();
      applyStimulus(5'b01000, 4'h0, 1'b0); tick();
      applyStimulus(5'b10000, 4'h0, 1'b0); tick();
      applyStimulus(5'b00001, 4'h0, 1'b0); tick();
      if (i == 14)
        checkOutput("cnt_15", 8'(instr_cnt), 8'd15);
    end
    checkOutput("cnt_wrap", 8'(instr_cnt), 8'd0);
    checkStatus("wrap_ok", 1'b0, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
